regbank_write_arbiter: RTL
==========================

# regbank_write_arbiter

- Shares the write port of a bank of 64-bit enable-gated registers (the `reg64_2` style: `clk`, `we`, `D`, async `reset`) among four requesters.
- Arbitrates with round-robin priority, with an optional lock so one requester can hold the bank for a multi-write sequence.
- Drives a one-hot per-register write enable plus a shared 64-bit data bus.
- Sits between the datapath/host-side writers and the register bank.

## Interface
Parameters:
- `NREGS`, 8: number of registers in the bank (2..16).
- `AW`, 3: register address width; `2**AW >= NREGS`.
- `DW`, 64: data width.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs immediately.
- `req`  in  4  per-requester write request, level, held until `ack`.
- `lock`  in  4  per-requester lock hold, qualified by `req` at grant time.
- `addr`  in  4*AW  packed target register index; requester i uses bits [i*AW +: AW].
- `wdata`  in  4*DW  packed write data; requester i uses bits [i*DW +: DW].
- `ack`  out  4  one-cycle pulse; write for requester i has been issued.
- `err`  out  4  one-cycle pulse with `ack`; addr >= NREGS, write dropped.
- `reg_we`  out  NREGS  one-hot write enable to the bank; at most one bit high.
- `reg_d`  out  DW  data to the bank, valid while any `reg_we` bit is high.
- `grant_id`  out  2  requester index of the current/last issued write.
- `locked`  out  1  high while in LOCKED state.

## Operation
- Eligible set each cycle:
  - `req & ~ack`: a requester whose ack is currently high is masked, so a held req is not re-granted.
  - In LOCKED state, only the lock owner is eligible.
- Round-robin: search starts at pointer `ptr`, wrapping 3→0. After a grant to i, `ptr` becomes (i+1) mod 4.
- Grant effects, all registered:
  - Next cycle `ack[i]`=1.
  - If addr < NREGS: `reg_we[addr]`=1 and `reg_d`=wdata_i.
  - Otherwise `reg_we`=0 and `err[i]`=1.
  - `grant_id`=i.
- `reg_d` holds its last value when idle; only `reg_we` is pulsed.
- State machine, two states:
  - ARB → LOCKED when the granted requester has `lock[i]`=1 at grant. Owner = i; `ptr` is not advanced.
  - LOCKED → ARB in the cycle after the owner's `lock` is sampled low. Owner's `req` is ignored once `lock` is low. `ptr` becomes (owner+1) mod 4.
  - In LOCKED, other requests wait indefinitely; the owner may drop `req` between writes while keeping `lock` high.
- `reset` (async): `ptr`=0, state ARB, `ack`/`err`/`reg_we`=0, `reg_d`=0, `grant_id`=0, `locked`=0.
  - A write in flight when `reset` asserts is lost; no `ack` is issued for it.

## Timing
- Latency: req sampled at edge k; `ack`, `reg_we`, `reg_d` high for exactly cycle k..k+1. The bank captures at edge k+1.
- Requester handshake:
  - Keep `req`/`addr`/`wdata`/`lock` stable until `ack` is seen.
  - It may change them in the cycle after `ack`.
  - A back-to-back request from the same requester is re-granted no earlier than 2 cycles after the previous grant edge.
- Aggregate throughput: one write per cycle when different requesters alternate. A single requester, including a LOCKED owner, gets one write per 2 cycles.
- Simultaneous requests: exactly one grant per cycle; losers keep `req` high and are served in round-robin order. Worst-case wait without lock is 3 grants.
- Dropping `req` before `ack` is illegal; behaviour is undefined and a checker flags it.

## Structure
- Shared package `regbank_pkg`: `NREQ`=4, state encoding (`ST_ARB`, `ST_LOCKED`), default `DW`/`AW`/`NREGS`.
- Sub-module `rr_pick4`: combinational round-robin selector. Inputs: 4-bit eligible mask, 2-bit `ptr`. Outputs: `valid`, 2-bit index.
- Top level holds the state register, owner, `ptr`, output registers and the addr decode to one-hot `reg_we`.

## Test plan
- Reset: assert `reset` mid-cycle with `req`=4'b1111 → all outputs 0 asynchronously; first grant after release goes to requester 0.
- Single write: req[2], addr=5, wdata=64'hDEAD_BEEF_0123_4567 at edge k → cycle k+1: `ack`=4'b0100, `reg_we`=8'b0010_0000, `reg_d` matches, `grant_id`=2; nothing asserted at k+2 while req still high that cycle.
- Round-robin: `req`=4'b1111 held (each requester re-requests after its ack) → grant order 0,1,2,3,0…; one `reg_we` pulse per cycle, never two bits high.
- Lock: requester 1 grants with `lock`=1, then writes addr 0,1,2 while req[3] is pending → `locked`=1, only requester 1 acked. Lock drops → next grant goes to 3, `ptr` then 0.
- Bad address (NREGS=6): addr=7 from requester 0 → `ack[0]`=1, `err[0]`=1, `reg_we`=0.
- Reset mid-LOCKED: assert `reset` with owner 3 → `locked`=0, state ARB, `ptr`=0; pending requests are re-arbitrated from 0.

Source files
------------

// File: rtl/regbank_pkg.sv
// ---------------------------------------------------------------------------
// regbank_pkg
//
// Purpose:
//   Shared definitions for the register-bank write arbiter: number of
//   requesters, the two arbiter state encodings, default bank geometry and a
//   small helper that turns a requester index into a one-hot vector.
//
// Contents:
//   NREQ            number of requesters sharing the bank write port (4)
//   ST_ARB          normal round-robin arbitration
//   ST_LOCKED       one requester owns the bank for a multi-write sequence
//   DEF_NREGS/AW/DW default register count, address width and data width
//   reqIdx_t        2-bit requester index type
//   reqOneHot()     requester index -> one-hot requester vector
// ---------------------------------------------------------------------------
package regbank_pkg;

    localparam int NREQ = 4;

    localparam int DEF_NREGS = 8;
    localparam int DEF_AW    = 3;
    localparam int DEF_DW    = 64;

    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    typedef logic [1:0] reqIdx_t;

    function automatic logic [NREQ-1:0] reqOneHot(input reqIdx_t idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/regbank_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regbank_write_arbiter_if
//
// Purpose:
//   Bundles the requester-side handshake and the bank-side write port of the
//   register-bank write arbiter.
//
// Signals:
//   req      [4]        per-requester write request, level, held until ack
//   lock     [4]        per-requester lock hold, qualified by req at grant
//   addr     [4*AW]     packed register index, requester i at [i*AW +: AW]
//   wdata    [4*DW]     packed write data, requester i at [i*DW +: DW]
//   ack      [4]        one-cycle pulse, write for requester i issued
//   err      [4]        one-cycle pulse with ack, address out of range
//   reg_we   [NREGS]    one-hot write enable to the bank
//   reg_d    [DW]       data to the bank
//   grant_id [2]        requester index of the current/last issued write
//   locked   [1]        arbiter is in the LOCKED state
//
// Modports:
//   master   requester side (drives req/lock/addr/wdata)
//   slave    arbiter side (drives ack/err/reg_we/reg_d/grant_id/locked)
// ---------------------------------------------------------------------------
interface regbank_write_arbiter_if #(
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int DW    = 64
);
    import regbank_pkg::*;

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    err;
    logic [NREGS-1:0]   reg_we;
    logic [DW-1:0]      reg_d;
    logic [1:0]         grant_id;
    logic               locked;

    modport master (
        output req, lock, addr, wdata,
        input  ack, err, reg_we, reg_d, grant_id, locked
    );

    modport slave (
        input  req, lock, addr, wdata,
        output ack, err, reg_we, reg_d, grant_id, locked
    );

endinterface

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
//
// Purpose:
//   Combinational round-robin selector over four requesters. The search
//   starts at ptr_i and wraps 3 -> 0; the first eligible requester wins.
//
// Ports:
//   eligible_i [4]  requesters allowed to win this cycle
//   ptr_i      [2]  highest-priority requester index
//   valid_o    [1]  some requester is eligible
//   idx_o      [2]  index of the winner (0 when valid_o is low)
// ---------------------------------------------------------------------------
module rr_pick4 (
    input  logic [3:0] eligible_i,
    input  logic [1:0] ptr_i,
    output logic       valid_o,
    output logic [1:0] idx_o
);

    // Walk the four positions starting at the pointer; the 2-bit candidate
    // wraps naturally, and the first hit is kept.
    always_comb begin
        logic       found;
        logic [1:0] cand;
        found = 1'b0;
        cand  = 2'd0;
        idx_o = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_i + 2'(k);
            if (!found && eligible_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// ---------------------------------------------------------------------------
// regbank_write_arbiter
//
// Purpose:
//   Shares the write port of a bank of NREGS enable-gated DW-bit registers
//   among four requesters. Round-robin priority, with an optional lock that
//   lets one requester keep the bank for a multi-write sequence. A grant at
//   edge k produces ack/reg_we/reg_d for exactly the cycle k..k+1, so the
//   bank captures the data at edge k+1.
//
// Parameters:
//   NREGS  number of registers in the bank (2..16)
//   AW     register address width, 2**AW >= NREGS
//   DW     data width
//
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-high; clears all state and outputs
//   bus    regbank_write_arbiter_if slave modport (requests in, bank
//          write port and status out)
// ---------------------------------------------------------------------------
module regbank_write_arbiter
    import regbank_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic                    clk,
    input  logic                    reset,
    regbank_write_arbiter_if.slave  bus
);

    logic [0:0]       state_q, state_d;
    reqIdx_t          owner_q, owner_d;
    reqIdx_t          ptr_q, ptr_d;
    logic [NREQ-1:0]  ackVec_q, ackVec_d;
    logic [NREQ-1:0]  errVec_q, errVec_d;
    logic [NREGS-1:0] regWe_q, regWe_d;
    logic [DW-1:0]    regD_q, regD_d;
    reqIdx_t          grantId_q, grantId_d;
    logic [NREQ-1:0]  pending_q, pending_d;

    logic [NREQ-1:0]  ownerMask;
    logic [NREQ-1:0]  eligible;
    logic             pickValid;
    reqIdx_t          pickIdx;
    logic [AW-1:0]    selAddr;
    logic [DW-1:0]    selData;
    logic             addrOk;
    logic             lockRelease;

    assign ownerMask   = reqOneHot(owner_q);
    assign lockRelease = (state_q == ST_LOCKED) && !bus.lock[owner_q];

    // A requester whose ack is high this cycle is already served, so its
    // still-high req must not win again. While LOCKED only the owner may
    // win, and only while it keeps its lock asserted.
    always_comb begin
        eligible = bus.req & ~ackVec_q;
        if (state_q == ST_LOCKED) begin
            if (bus.lock[owner_q]) begin
                eligible = eligible & ownerMask;
            end else begin
                eligible = '0;
            end
        end
    end

    rr_pick4 picker (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .valid_o    (pickValid),
        .idx_o      (pickIdx)
    );

    // Winner's address and data; the address is range-checked against the
    // real register count because AW may cover more indices than exist.
    always_comb begin
        selAddr = bus.addr[int'(pickIdx)*AW +: AW];
        selData = bus.wdata[int'(pickIdx)*DW +: DW];
        addrOk  = (int'(selAddr) < NREGS);
    end

    // Next-state logic. Outputs default to an idle cycle (pulses low, data
    // and grant_id holding). The pointer only advances on an unlocked grant
    // or when a lock is released; entering LOCKED leaves it untouched so
    // the owner's neighbour is next in line once the lock drops.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        ackVec_d  = '0;
        errVec_d  = '0;
        regWe_d   = '0;
        regD_d    = regD_q;
        grantId_d = grantId_q;

        if (pickValid) begin
            ackVec_d  = reqOneHot(pickIdx);
            grantId_d = pickIdx;
            if (addrOk) begin
                regWe_d = NREGS'(1) << selAddr;
                regD_d  = selData;
            end else begin
                errVec_d = reqOneHot(pickIdx);
            end
            if (state_q == ST_ARB) begin
                if (bus.lock[pickIdx]) begin
                    state_d = ST_LOCKED;
                    owner_d = pickIdx;
                end else begin
                    ptr_d = pickIdx + 2'd1;
                end
            end
        end

        if (lockRelease) begin
            state_d = ST_ARB;
            ptr_d   = owner_q + 2'd1;
        end
    end

    // Requests that were high, not granted and not just acknowledged must
    // stay high until served. The LOCKED owner is exempt: it may pause
    // between writes, and its req is ignored once the lock drops.
    always_comb begin
        pending_d = bus.req & ~ackVec_d & ~ackVec_q;
        if (state_q == ST_LOCKED) begin
            pending_d = pending_d & ~ownerMask;
        end
    end

    // State and output registers; reset clears everything at once, so a
    // grant issued just before reset never shows an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_ARB;
            owner_q   <= 2'd0;
            ptr_q     <= 2'd0;
            ackVec_q  <= '0;
            errVec_q  <= '0;
            regWe_q   <= '0;
            regD_q    <= '0;
            grantId_q <= 2'd0;
            pending_q <= '0;
        end else begin
            assert ((pending_q & ~bus.req) == '0);
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            ackVec_q  <= ackVec_d;
            errVec_q  <= errVec_d;
            regWe_q   <= regWe_d;
            regD_q    <= regD_d;
            grantId_q <= grantId_d;
            pending_q <= pending_d;
        end
    end

    assign bus.ack      = ackVec_q;
    assign bus.err      = errVec_q;
    assign bus.reg_we   = regWe_q;
    assign bus.reg_d    = regD_q;
    assign bus.grant_id = grantId_q;
    assign bus.locked   = (state_q == ST_LOCKED);

endmodule
